// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the uart_tx round-robin scheduler.
// Holds the FSM state encoding, the grant index width and the default tag nibble.
package uart_sched_pkg;

    localparam int         GRANT_W = 3;
    localparam int         MAX_REQ = 8;
    localparam logic [7:0] TAG_NIB = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_ACT,
        ST_WAIT_DONE,
        ST_DRAIN
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_picker.sv
// Combinational round-robin picker: first valid requester after the last grant,
// wrapping modulo NUM_REQ, plus an any-valid flag.
module rr_picker
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] grant,
    output logic               any
);

    // Zero-extended so a GRANT_W-bit index always selects in range.
    logic [MAX_REQ-1:0] valid_ext;
    logic [GRANT_W-1:0] idx;

    assign valid_ext = MAX_REQ'(valid);

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GRANT_W'((int'(last) + k) % NUM_REQ);
            if (!any && valid_ext[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ byte producers with round-robin arbitration and a frame watchdog.
// Optional macro UART_CHAN_TAG_EN prefixes every payload frame with a channel tag frame.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 16384
`ifdef UART_CHAN_TAG_EN
    ,
    parameter logic [7:0] TAG_BASE = TAG_NIB
`endif
)(
    input  logic                 osc_clk,
    input  logic                 i_Rst,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [GRANT_W-1:0]   o_Grant_Id,
    output logic                 o_Busy,
    output logic                 o_Timeout_Err
);

    localparam int WD_W = ($clog2(TIMEOUT_CLKS) > 15) ? $clog2(TIMEOUT_CLKS) : 15;

    sched_state_t       state;
    sched_state_t       state_next;
    logic [GRANT_W-1:0] last_q;
    logic [GRANT_W-1:0] pick_grant;
    logic               pick_any;
    logic [7:0]         byte_q;
    logic [WD_W-1:0]    wd_q;
    logic               wd_expired;
`ifdef UART_CHAN_TAG_EN
    logic               tag_phase_q;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (i_Req_Valid),
        .last  (last_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CLKS - 1));
    assign o_Busy     = (state != ST_IDLE);

    // IDLE also waits out a frame uart_tx may still be sending after a reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!i_Tx_Active && !i_Tx_Done && pick_any)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = pick_any ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (wd_expired)
                    state_next = ST_IDLE;
                else if (i_Tx_Active)
                    state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (wd_expired)
                    state_next = ST_IDLE;
                else if (i_Tx_Done)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wd_expired)
                    state_next = ST_IDLE;
                else if (!i_Tx_Done) begin
`ifdef UART_CHAN_TAG_EN
                    state_next = tag_phase_q ? ST_ISSUE : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Ack, grant and DV are registered, so ack trails LOAD and DV trails ISSUE by one cycle.
    always_ff @(posedge osc_clk) begin
        if (i_Rst) begin
            state         <= ST_IDLE;
            last_q        <= GRANT_W'(NUM_REQ - 1);
            o_Req_Ack     <= '0;
            o_Tx_DV       <= 1'b0;
            o_Tx_Byte     <= '0;
            o_Grant_Id    <= '0;
            o_Timeout_Err <= 1'b0;
            byte_q        <= '0;
            wd_q          <= '0;
`ifdef UART_CHAN_TAG_EN
            tag_phase_q   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            o_Req_Ack <= '0;
            o_Tx_DV   <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (pick_any) begin
                        o_Req_Ack  <= NUM_REQ'(1) << pick_grant;
                        o_Grant_Id <= pick_grant;
                        last_q     <= pick_grant;
                        byte_q     <= i_Req_Byte[int'(pick_grant)*8 +: 8];
`ifdef UART_CHAN_TAG_EN
                        tag_phase_q <= 1'b1;
`endif
                    end
                end
                ST_ISSUE: begin
                    o_Tx_DV <= 1'b1;
                    wd_q    <= '0;
`ifdef UART_CHAN_TAG_EN
                    o_Tx_Byte <= tag_phase_q ? (TAG_BASE | {5'b0, o_Grant_Id}) : byte_q;
`else
                    o_Tx_Byte <= byte_q;
`endif
                end
                ST_WAIT_ACT, ST_WAIT_DONE, ST_DRAIN: begin
                    wd_q <= wd_q + 1'b1;
                    if (wd_expired)
                        o_Timeout_Err <= 1'b1;
`ifdef UART_CHAN_TAG_EN
                    if (wd_expired || (state == ST_DRAIN && !i_Tx_Done))
                        tag_phase_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural uart_tx (CLKS_PER_BIT=16, 2-cycle Done).
// The tag-frame step runs only when UART_CHAN_TAG_EN is defined.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CPB     = 16;

    logic                 osc_clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_byte = '0;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_active;
    logic                 tx_done;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;

    int num_asserts = 0;
    int num_fails   = 0;

    // Behavioural uart_tx: no reset, so a frame in flight survives a scheduler reset.
    logic       m_busy = 1'b0;
    logic [9:0] m_shift = '1;
    logic [3:0] m_bit = '0;
    int         m_cnt = 0;
    int         m_done_cnt = 0;
    logic       done_tie_low = 1'b0;
    logic       serial;

    always #5 osc_clk = ~osc_clk;

    uart_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .TIMEOUT_CLKS (256)
    ) dut (
        .osc_clk       (osc_clk),
        .i_Rst         (rst),
        .i_Req_Valid   (req_valid),
        .i_Req_Byte    (req_byte),
        .o_Req_Ack     (req_ack),
        .o_Tx_DV       (tx_dv),
        .o_Tx_Byte     (tx_byte),
        .i_Tx_Active   (tx_active),
        .i_Tx_Done     (tx_done),
        .o_Grant_Id    (grant_id),
        .o_Busy        (busy),
        .o_Timeout_Err (timeout_err)
    );

    always @(posedge osc_clk) begin
        if (m_done_cnt > 0)
            m_done_cnt <= m_done_cnt - 1;
        if (!m_busy) begin
            if (tx_dv) begin
                m_busy  <= 1'b1;
                m_shift <= {1'b1, tx_byte, 1'b0};
                m_bit   <= '0;
                m_cnt   <= 0;
            end
        end else if (m_cnt == CPB - 1) begin
            m_cnt <= 0;
            if (m_bit == 4'd9) begin
                m_busy     <= 1'b0;
                m_done_cnt <= 2;
            end else begin
                m_bit <= m_bit + 4'd1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign serial    = m_busy ? m_shift[m_bit] : 1'b1;
    assign tx_active = m_busy;
    assign tx_done   = (m_done_cnt > 0) && !done_tie_low;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_asserts++;
        assert (observed === expected)
        else begin
            num_fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge osc_clk);
        rst = 1'b1;
        repeat (2) @(negedge osc_clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output int idx);
        idx = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge osc_clk);
            if (req_ack != '0) begin
                idx = 99;
                for (int b = 0; b < NUM_REQ; b++)
                    if (req_ack == (NUM_REQ'(1) << b))
                        idx = b;
                break;
            end
        end
    endtask

    task automatic wait_dv(input int budget, output logic [7:0] seen, output int acks);
        seen = 8'hxx;
        acks = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge osc_clk);
            if (req_ack != '0)
                acks++;
            if (tx_dv) begin
                seen = tx_byte;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge osc_clk);
            if (!busy)
                break;
        end
        check_output("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int         idx;
        int         acks;
        int         cnt;
        logic [7:0] seen;
        logic [9:0] line_exp;
        bit         early_issue;

        // Reset state
        repeat (3) @(negedge osc_clk);
        check_output("rst_ack",   32'(req_ack),     32'd0);
        check_output("rst_dv",    32'(tx_dv),       32'd0);
        check_output("rst_byte",  32'(tx_byte),     32'd0);
        check_output("rst_busy",  32'(busy),        32'd0);
        check_output("rst_grant", 32'(grant_id),    32'd0);
        check_output("rst_err",   32'(timeout_err), 32'd0);
        rst = 1'b0;

        // 1) Single requester, latency and serial waveform
        @(negedge osc_clk);
        req_byte[15:8] = 8'h5A;
        req_valid      = 4'b0010;
        @(negedge osc_clk);
        check_output("t1_ack_early", 32'(req_ack), 32'd0);
        @(negedge osc_clk);
        check_output("t1_ack",   32'(req_ack),  32'b0010);
        check_output("t1_grant", 32'(grant_id), 32'd1);
        req_valid = '0;
        @(negedge osc_clk);
        check_output("t1_dv",   32'(tx_dv),   32'd1);
        check_output("t1_byte", 32'(tx_byte), 32'h5A);
        @(negedge osc_clk);
        check_output("t1_dv_one_cycle", 32'(tx_dv),     32'd0);
        check_output("t1_active",       32'(tx_active), 32'd1);
        line_exp = 10'b1010110100;
        for (int b = 0; b < 10; b++) begin
            repeat ((b == 0) ? 8 : CPB) @(negedge osc_clk);
            check_output($sformatf("t1_line_bit%0d", b), 32'(serial), 32'(line_exp[b]));
        end
        wait_idle(100);
        check_output("t1_done_low", 32'(tx_done), 32'd0);

        // 2) All four continuously valid: grants 0,1,2,3,0
        apply_reset();
        req_byte  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_ack(400, idx);
            check_output($sformatf("t2_grant%0d", f), 32'(idx), 32'(f % 4));
            if (f == 4)
                req_valid = '0;
            wait_dv(10, seen, acks);
            check_output($sformatf("t2_byte%0d", f), 32'(seen), 32'(8'h10 + (f % 4)));
            check_output($sformatf("t2_single_ack%0d", f), 32'(acks), 32'd0);
        end
        wait_idle(400);

        // 3) Req2 rises mid-frame of req0 while req0 stays valid
        req_byte[7:0]   = 8'h33;
        req_byte[23:16] = 8'h44;
        req_valid       = 4'b0001;
        wait_ack(50, idx);
        check_output("t3_first_grant", 32'(idx), 32'd0);
        repeat (50) @(negedge osc_clk);
        req_valid = 4'b0101;
        wait_ack(400, idx);
        check_output("t3_rr_grant", 32'(idx), 32'd2);
        req_valid = '0;
        wait_idle(400);

        // 4) Done never arrives: watchdog fires 256 cycles after DV
        done_tie_low   = 1'b1;
        req_byte[15:8] = 8'h66;
        req_valid      = 4'b0010;
        wait_ack(50, idx);
        check_output("t4_grant", 32'(idx), 32'd1);
        req_valid = '0;
        wait_dv(10, seen, acks);
        check_output("t4_byte", 32'(seen), 32'h66);
        cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge osc_clk);
            if (timeout_err) begin
                cnt = i;
                break;
            end
        end
        check_output("t4_timeout_cycles", 32'(cnt),  32'd256);
        check_output("t4_idle_after_to",  32'(busy), 32'd0);
        done_tie_low    = 1'b0;
        req_byte[31:24] = 8'h99;
        req_valid       = 4'b1000;
        wait_ack(50, idx);
        check_output("t4_next_grant", 32'(idx), 32'd3);
        req_valid = '0;
        wait_dv(10, seen, acks);
        check_output("t4_next_byte", 32'(seen), 32'h99);
        wait_idle(400);
        check_output("t4_err_sticky", 32'(timeout_err), 32'd1);

        // 5) Reset during data bits; pending req2 served only once uart_tx is idle
        req_byte[7:0]   = 8'h77;
        req_byte[23:16] = 8'h55;
        req_valid       = 4'b0001;
        wait_ack(50, idx);
        req_valid = '0;
        wait_dv(10, seen, acks);
        repeat (40) @(negedge osc_clk);
        req_valid = 4'b0100;
        rst       = 1'b1;
        @(negedge osc_clk);
        check_output("t5_rst_ack",   32'(req_ack),     32'd0);
        check_output("t5_rst_dv",    32'(tx_dv),       32'd0);
        check_output("t5_rst_busy",  32'(busy),        32'd0);
        check_output("t5_rst_grant", 32'(grant_id),    32'd0);
        check_output("t5_rst_err",   32'(timeout_err), 32'd0);
        check_output("t5_uart_still_active", 32'(tx_active), 32'd1);
        rst = 1'b0;
        early_issue = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge osc_clk);
            if (!tx_active && !tx_done)
                break;
            if (tx_dv || req_ack != '0)
                early_issue = 1'b1;
        end
        check_output("t5_no_issue_while_uart_busy", 32'(early_issue), 32'd0);
        wait_ack(10, idx);
        check_output("t5_pending_grant", 32'(idx), 32'd2);
        req_valid = '0;
        wait_dv(10, seen, acks);
        check_output("t5_pending_byte", 32'(seen), 32'h55);
        wait_idle(400);

`ifdef UART_CHAN_TAG_EN
        // 6) Tag frame precedes payload, single ack
        apply_reset();
        req_byte[31:24] = 8'hC3;
        req_valid       = 4'b1000;
        wait_ack(50, idx);
        check_output("t6_grant", 32'(idx), 32'd3);
        req_valid = '0;
        wait_dv(10, seen, acks);
        check_output("t6_tag_byte", 32'(seen), 32'hA3);
        wait_dv(400, seen, acks);
        check_output("t6_payload_byte", 32'(seen), 32'hC3);
        check_output("t6_single_ack",   32'(acks), 32'd0);
        wait_idle(400);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
        $finish;
    end

endmodule
